// File: rtl/cc_det_pkg.sv
// Shared definitions for the CC attach detector: Rp level codes, default
// thresholds in millivolts and the attach FSM state encoding.
package cc_det_pkg;

  localparam logic [1:0] LVL_OPEN = 2'd0;
  localparam logic [1:0] LVL_DEF  = 2'd1;
  localparam logic [1:0] LVL_1A5  = 2'd2;
  localparam logic [1:0] LVL_3A0  = 2'd3;

  localparam int unsigned TH0_DEF = 200;
  localparam int unsigned TH1_DEF = 660;
  localparam int unsigned TH2_DEF = 1230;
  localparam int unsigned HYS_DEF = 40;

  typedef enum logic {
    DETACHED = 1'b0,
    ATTACHED = 1'b1
  } att_state_e;

  // Falling threshold: rising threshold minus hysteresis, clamped at zero.
  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : 0;
  endfunction

endpackage

// File: rtl/cc_lvl_deb.sv
// One CC channel: quantises the voltage into an Rp level with falling
// hysteresis, then debounces that level into lvl_stb.
module cc_lvl_deb
  import cc_det_pkg::*;
#(
  parameter int unsigned VW  = 16,
  parameter int unsigned DBW = 16,
  parameter int unsigned TH0 = TH0_DEF,
  parameter int unsigned TH1 = TH1_DEF,
  parameter int unsigned TH2 = TH2_DEF,
  parameter int unsigned HYS = HYS_DEF
) (
  input  logic           clk,
  input  logic           rstz,
  input  logic           enable,
  input  logic [VW-1:0]  v,
  input  logic [DBW-1:0] deb_cyc,
  output logic [1:0]     lvl_raw,
  output logic [1:0]     lvl_stb,
  output logic           lvl_chg
);

  localparam logic [VW-1:0] RISE1 = VW'(TH0);
  localparam logic [VW-1:0] RISE2 = VW'(TH1);
  localparam logic [VW-1:0] RISE3 = VW'(TH2);
  localparam logic [VW-1:0] FALL1 = VW'(sat_sub(TH0, HYS));
  localparam logic [VW-1:0] FALL2 = VW'(sat_sub(TH1, HYS));
  localparam logic [VW-1:0] FALL3 = VW'(sat_sub(TH2, HYS));

  logic [1:0]     raw_q, raw_d;
  logic [1:0]     stb_q, stb_d;
  logic [1:0]     lat_q, lat_d;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic           chg_q, chg_d;
  logic [1:0]     rise, hold;
  logic [DBW-1:0] cnt_eff;

  always_comb begin
    rise = LVL_OPEN;
    if (v >= RISE1) rise = LVL_DEF;
    if (v >= RISE2) rise = LVL_1A5;
    if (v >= RISE3) rise = LVL_3A0;
    // A level already held is kept until v drops below its falling threshold.
    hold = LVL_OPEN;
    if ((raw_q >= LVL_DEF) && (v >= FALL1)) hold = LVL_DEF;
    if ((raw_q >= LVL_1A5) && (v >= FALL2)) hold = LVL_1A5;
    if ((raw_q == LVL_3A0) && (v >= FALL3)) hold = LVL_3A0;
    raw_d = enable ? ((rise > hold) ? rise : hold) : LVL_OPEN;
  end

  always_comb begin
    cnt_eff = (raw_q != lat_q) ? '0 : cnt_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    stb_d   = stb_q;
    chg_d   = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      lat_d = LVL_OPEN;
      stb_d = LVL_OPEN;
    end else if (raw_q == stb_q) begin
      cnt_d = '0;
      lat_d = raw_q;
    end else if (cnt_eff == deb_cyc) begin
      stb_d = raw_q;
      chg_d = 1'b1;
      cnt_d = '0;
      lat_d = raw_q;
    end else begin
      cnt_d = (&cnt_eff) ? cnt_eff : cnt_eff + DBW'(1);
      lat_d = raw_q;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      raw_q <= LVL_OPEN;
      stb_q <= LVL_OPEN;
      lat_q <= LVL_OPEN;
      cnt_q <= '0;
      chg_q <= 1'b0;
    end else begin
      raw_q <= raw_d;
      stb_q <= stb_d;
      lat_q <= lat_d;
      cnt_q <= cnt_d;
      chg_q <= chg_d;
    end
  end

  assign lvl_raw = raw_q;
  assign lvl_stb = stb_q;
  assign lvl_chg = chg_q;

endmodule

// File: rtl/cc_attach_detector.sv
// N-channel CC attach detector: per-channel level debounce plus an attach
// FSM that picks the oriented channel and reports the advertised Rp level.
module cc_attach_detector
  import cc_det_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned VW  = 16,
  parameter int unsigned DBW = 16,
  parameter int unsigned TH0 = TH0_DEF,
  parameter int unsigned TH1 = TH1_DEF,
  parameter int unsigned TH2 = TH2_DEF,
  parameter int unsigned HYS = HYS_DEF,
  localparam int unsigned OW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rstz,
  input  logic               enable,
  input  logic [NCH*VW-1:0]  v_ch,
  input  logic [DBW-1:0]     deb_cyc,
  output logic [2*NCH-1:0]   lvl_raw,
  output logic [2*NCH-1:0]   lvl_stb,
  output logic [NCH-1:0]     lvl_chg,
  output logic               attached,
  output logic [OW-1:0]      ori,
  output logic [1:0]         rp_lvl,
  output logic               dbg_acc,
  output logic               att_pulse,
  output logic               det_pulse
);

  logic [1:0] stb_arr [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cc_lvl_deb #(
      .VW (VW),
      .DBW(DBW),
      .TH0(TH0),
      .TH1(TH1),
      .TH2(TH2),
      .HYS(HYS)
    ) u_deb (
      .clk    (clk),
      .rstz   (rstz),
      .enable (enable),
      .v      (v_ch[i*VW +: VW]),
      .deb_cyc(deb_cyc),
      .lvl_raw(lvl_raw[2*i +: 2]),
      .lvl_stb(stb_arr[i]),
      .lvl_chg(lvl_chg[i])
    );
    assign lvl_stb[2*i +: 2] = stb_arr[i];
  end

  att_state_e  state_q, state_d;
  logic [OW-1:0] ori_q, ori_d;
  logic        att_pulse_q, att_pulse_d;
  logic        det_pulse_q, det_pulse_d;
  logic [1:0]  best_lvl;
  logic [OW-1:0] best_idx;
  logic        all_nz;

  // Highest stable level wins; strict compare keeps the lowest index on a tie.
  always_comb begin
    best_lvl = LVL_OPEN;
    best_idx = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (stb_arr[i] > best_lvl) begin
        best_lvl = stb_arr[i];
        best_idx = OW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q     <= DETACHED;
      ori_q       <= '0;
      att_pulse_q <= 1'b0;
      det_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ori_q       <= ori_d;
      att_pulse_q <= att_pulse_d;
      det_pulse_q <= det_pulse_d;
    end
  end

  // Detach always lands in DETACHED first, so re-attach is seen a cycle later.
  always_comb begin
    state_d     = state_q;
    ori_d       = ori_q;
    att_pulse_d = 1'b0;
    det_pulse_d = 1'b0;
    if (!enable) begin
      state_d = DETACHED;
      ori_d   = '0;
    end else begin
      case (state_q)
        DETACHED: begin
          if (best_lvl != LVL_OPEN) begin
            state_d     = ATTACHED;
            ori_d       = best_idx;
            att_pulse_d = 1'b1;
          end
        end
        ATTACHED: begin
          if (stb_arr[ori_q] == LVL_OPEN) begin
            state_d     = DETACHED;
            ori_d       = '0;
            det_pulse_d = 1'b1;
          end
        end
        default: state_d = DETACHED;
      endcase
    end
  end

  always_comb begin
    attached = (state_q == ATTACHED);
    rp_lvl   = attached ? stb_arr[ori_q] : LVL_OPEN;
    all_nz   = 1'b1;
    for (int i = 0; i < int'(NCH); i++) begin
      if (stb_arr[i] == LVL_OPEN) all_nz = 1'b0;
    end
    dbg_acc = (NCH > 1) && attached && all_nz;
  end

  assign ori       = ori_q;
  assign att_pulse = att_pulse_q;
  assign det_pulse = det_pulse_q;

endmodule
